// File: rtl/printer_pkg.sv
// Shared types and default parameter values for the printer device model.
package printer_pkg;

  typedef enum logic [0:0] {
    PRN_IDLE = 1'b0,
    PRN_BUSY = 1'b1
  } prn_state_e;

  localparam int PRN_DATA_W    = 8;
  localparam int PRN_PRINT_LAT = 4;
  localparam int PRN_BUSY_CYC  = 8;
  localparam int PRN_CNT_W     = 16;

endpackage

// File: rtl/printer_param_delay_line.sv
// Fixed-latency {valid, data} shift register between the accept edge and the
// printer output register. Asynchronous clear drops every in-flight character.
module print_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  // Shift every stage one step toward the output; stage 0 loads the capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= i_vld;
      data_q[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign o_vld  = vld_q[DEPTH-1];
  assign o_data = data_q[DEPTH-1];

endmodule

// File: rtl/printer_param.sv
// Parametrised printer device model: one character per i_tr/o_rdy handshake,
// printed PRINT_LAT cycles later, busy for BUSY_CYC cycles per character.
// Handshake: a character is accepted on a rising edge where i_tr=1 and o_rdy=1;
// i_tr while o_rdy=0 is an overrun (sticky o_err) and is otherwise ignored.
module printer_param
  import printer_pkg::*;
#(
  parameter int DATA_W    = PRN_DATA_W,
  parameter int PRINT_LAT = PRN_PRINT_LAT,
  parameter int BUSY_CYC  = PRN_BUSY_CYC,
  parameter int CNT_W     = PRN_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tr,
  input  logic [DATA_W-1:0] i_pd,
  input  logic              i_clr_err,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_cnt,
  output prn_state_e        o_state
);

  localparam int BW = $clog2(BUSY_CYC) + 1;

  if (PRINT_LAT < 1) begin : g_bad_lat
    $error("printer_param: PRINT_LAT must be >= 1");
  end
  if (BUSY_CYC < PRINT_LAT) begin : g_bad_busy
    $error("printer_param: BUSY_CYC must be >= PRINT_LAT");
  end

  prn_state_e        state_q, state_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              busy_last;
  logic              accept;
  logic              overrun;
  logic              err_d;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dl_vld;
  logic [DATA_W-1:0] dl_data;

  assign busy_last = (bcnt_q == BW'(BUSY_CYC - 1));

  // State and busy-counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PRN_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next state: leave IDLE on a request, leave BUSY after BUSY_CYC edges.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      PRN_IDLE: begin
        if (i_tr) begin
          state_d = PRN_BUSY;
          bcnt_d  = '0;
        end
      end
      PRN_BUSY: begin
        if (busy_last) begin
          state_d = PRN_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = PRN_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // FSM outputs: ready in IDLE, accept/overrun qualify the request, set beats clear.
  always_comb begin
    o_rdy   = (state_q == PRN_IDLE);
    accept  = o_rdy & i_tr;
    overrun = ~o_rdy & i_tr;
    err_d   = err_q;
    if (overrun) begin
      err_d = 1'b1;
    end else if (i_clr_err) begin
      err_d = 1'b0;
    end
  end

  print_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (PRINT_LAT)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (accept),
    .i_data  (i_pd),
    .o_vld   (dl_vld),
    .o_data  (dl_data)
  );

  // Output register, print strobe, printed-character counter and overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= dl_vld;
      err_q   <= err_d;
      if (dl_vld) begin
        data_q <= dl_data;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_cnt   = cnt_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_printer_param.sv
// Bench for printer_param: a default instance and a DATA_W=16, PRINT_LAT=BUSY_CYC=1,
// CNT_W=2 instance, checked cycle by cycle against a timing-arithmetic model.
module tb_printer_param;
  import printer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  logic        a_tr, a_clr;
  logic [7:0]  a_pd, a_data;
  logic        a_rdy, a_valid, a_err;
  logic [15:0] a_cnt;
  prn_state_e  a_st;

  printer_param dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tr(a_tr), .i_pd(a_pd), .i_clr_err(a_clr),
    .o_rdy(a_rdy), .o_data(a_data), .o_valid(a_valid), .o_err(a_err),
    .o_cnt(a_cnt), .o_state(a_st)
  );

  // ---------------- DUT B (wide, minimum latency) ----------------
  logic        b_tr, b_clr;
  logic [15:0] b_pd, b_data;
  logic        b_rdy, b_valid, b_err;
  logic [1:0]  b_cnt;
  prn_state_e  b_st;

  printer_param #(.DATA_W(16), .PRINT_LAT(1), .BUSY_CYC(1), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tr(b_tr), .i_pd(b_pd), .i_clr_err(b_clr),
    .o_rdy(b_rdy), .o_data(b_data), .o_valid(b_valid), .o_err(b_err),
    .o_cnt(b_cnt), .o_state(b_st)
  );

  // ---------------- observed outputs of selected DUT ----------------
  logic        sel;
  logic        obs_rdy, obs_valid, obs_err;
  logic [15:0] obs_data, obs_cnt;
  prn_state_e  obs_st;
  logic [34:0] obs_vec;

  always_comb begin
    if (sel) begin
      obs_rdy = b_rdy; obs_valid = b_valid; obs_err = b_err;
      obs_data = b_data; obs_cnt = {14'h0, b_cnt}; obs_st = b_st;
    end else begin
      obs_rdy = a_rdy; obs_valid = a_valid; obs_err = a_err;
      obs_data = {8'h00, a_data}; obs_cnt = a_cnt; obs_st = a_st;
    end
  end
  assign obs_vec = {obs_rdy, obs_valid, obs_err, obs_data, obs_cnt};

  // ---------------- reference model ----------------
  // Printer timing from rules: accept at edge n -> busy through edge n+bc,
  // print strobe after edge n+pl; scoreboard holds pending prints.
  int          pl, bc, cnt_mod;
  int          cyc;
  int          busy_end;
  logic [15:0] exp_q[$];
  int          exp_edge_q[$];
  logic        m_rdy, m_valid, m_err;
  logic [15:0] m_data;
  int          m_cnt;

  int errors = 0;
  int checks = 0;

  function automatic logic [34:0] m_vec();
    return {m_rdy, m_valid, m_err, m_data, m_cnt[15:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_edge_q.delete();
    busy_end = cyc;
    m_rdy    = 1'b1;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_data   = '0;
    m_cnt    = 0;
  endtask

  task automatic drive_reset();
    a_tr = 0; a_clr = 0; b_tr = 0; b_clr = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic tr, input logic [15:0] pd, input logic clr);
    logic [15:0] pdm;
    @(negedge clk);
    pdm = sel ? pd : {8'h00, pd[7:0]};
    if (sel) begin
      b_tr = tr; b_pd = pd; b_clr = clr; a_tr = 1'b0; a_clr = 1'b0;
    end else begin
      a_tr = tr; a_pd = pd[7:0]; a_clr = clr; b_tr = 1'b0; b_clr = 1'b0;
    end
    @(posedge clk);
    cyc++;
    if (tr && m_rdy) begin
      busy_end = cyc + bc;
      exp_q.push_back(pdm);
      exp_edge_q.push_back(cyc + pl);
    end
    if (tr && !m_rdy) m_err = 1'b1;
    else if (clr)     m_err = 1'b0;
    m_rdy   = (cyc >= busy_end);
    m_valid = 1'b0;
    if (exp_edge_q.size() > 0 && exp_edge_q[0] == cyc) begin
      m_valid = 1'b1;
      m_data  = exp_q.pop_front();
      void'(exp_edge_q.pop_front());
      m_cnt   = (m_cnt + 1) % cnt_mod;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_tr = 0; a_clr = 0; a_pd = 0; b_tr = 0; b_clr = 0; b_pd = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs_vec !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_a rdy/vld/err/data/cnt got=%h exp=%h", obs_vec, {1'b1, 34'h0});
    end
    checks++;
    if (obs_st !== PRN_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", obs_st, PRN_IDLE);
    end
    checks++;
    if ({b_rdy, b_valid, b_err, b_data, b_cnt} !== {1'b1, 1'b0, 1'b0, 16'h0, 2'h0}) begin
      errors++;
      $display("FAIL reset_b got=%b%b%b_%h_%h exp=100_0000_0", b_rdy, b_valid, b_err, b_data, b_cnt);
    end
    model_reset();
    release_reset();
  endtask

  task automatic test_single();
    int pulses = 0, pulse_i = -1, low = 0;
    logic [15:0] pulse_d = '0;
    for (int i = 0; i < 14; i++) begin
      step(i == 0, (i == 0) ? 16'h00A5 : (i == 1) ? 16'h003C : 16'($urandom), 1'b0);
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL single cyc=%0d rdy/vld/err/data/cnt got=%h exp=%h", i, obs_vec, m_vec());
      end
      if (obs_valid) begin pulses++; pulse_i = i; pulse_d = obs_data; end
      if (!obs_rdy) low++;
      if (i == 1) begin
        checks++;
        if (obs_st !== PRN_BUSY) begin
          errors++;
          $display("FAIL single_state got=%0d exp=%0d", obs_st, PRN_BUSY);
        end
      end
    end
    checks++;
    if (pulses !== 1 || pulse_i !== 4 || pulse_d !== 16'h00A5) begin
      errors++;
      $display("FAIL single_print got pulses=%0d at=%0d data=%h exp pulses=1 at=4 data=00a5", pulses, pulse_i, pulse_d);
    end
    checks++;
    if (low !== 8) begin
      errors++;
      $display("FAIL single_busy got=%0d exp=8", low);
    end
    checks++;
    if (obs_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_cnt got=%0d exp=1", obs_cnt);
    end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step(i == 0 || i == 3, 16'($urandom), 1'b0);
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL overrun cyc=%0d got=%h exp=%h", i, obs_vec, m_vec());
      end
      if (obs_valid) pulses++;
    end
    checks++;
    if (obs_err !== 1'b1 || pulses !== 1) begin
      errors++;
      $display("FAIL overrun_flag got err=%b pulses=%0d exp err=1 pulses=1", obs_err, pulses);
    end
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%b exp=0", obs_err);
    end
    step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'($urandom), 1'b1);
    checks++;
    if (obs_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins got=%b exp=1", obs_err);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'($urandom), i == 9);
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL overrun_tail cyc=%0d got=%h exp=%h", i, obs_vec, m_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    drive_reset();
    checks++;
    if (obs_vec !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs_vec, {1'b1, 34'h0});
    end
    release_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'($urandom), 1'b0);
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, obs_vec, m_vec());
      end
      if (obs_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_discard got pulses=%0d exp=0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, np = 0;
    int p_cyc[3];
    logic [15:0] p_dat[3];
    int cnt0;
    logic pre;
    cnt0 = m_cnt;
    for (int i = 0; i < 34; i++) begin
      pre = m_rdy;
      step(i < 27, 16'(acc + 1), 1'b0);
      if (i < 27 && pre) acc++;
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obs_vec, m_vec());
      end
      if (obs_valid) begin
        if (np < 3) begin p_cyc[np] = i; p_dat[np] = obs_data; end
        np++;
      end
    end
    checks++;
    if (np !== 3) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d exp=3", np);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (p_dat[k] !== 16'(k + 1) || (k > 0 && p_cyc[k] - p_cyc[k-1] !== 9)) begin
          errors++;
          $display("FAIL b2b_print%0d got data=%h gap=%0d exp data=%0d gap=9", k, p_dat[k],
                   (k > 0) ? p_cyc[k] - p_cyc[k-1] : 9, k + 1);
        end
      end
    end
    checks++;
    if (obs_err !== 1'b1 || obs_cnt !== 16'(cnt0 + 3)) begin
      errors++;
      $display("FAIL b2b_final got err=%b cnt=%0d exp err=1 cnt=%0d", obs_err, obs_cnt, cnt0 + 3);
    end
    step(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 320; i++) begin
      if (i < 300) step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 7) == 0);
      else         step(1'b0, 16'($urandom), 1'b0);
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, m_vec());
      end
    end
  endtask

  task automatic test_wide();
    int acc = 0, pulses = 0;
    logic pre;
    sel = 1'b1; pl = 1; bc = 1; cnt_mod = 4;
    drive_reset();
    release_reset();
    for (int i = 0; i < 12; i++) begin
      pre = m_rdy;
      step(acc < 5, 16'($urandom), 1'b0);
      if (acc < 5 && pre) acc++;
      checks++;
      if (obs_vec !== m_vec()) begin
        errors++;
        $display("FAIL wide cyc=%0d got=%h exp=%h", i, obs_vec, m_vec());
      end
      if (obs_valid) begin
        pulses++;
        checks++;
        if (obs_rdy !== 1'b1) begin
          errors++;
          $display("FAIL wide_same_edge cyc=%0d got rdy=%b exp=1", i, obs_rdy);
        end
      end
    end
    checks++;
    if (pulses !== 5 || obs_cnt !== 16'd1) begin
      errors++;
      $display("FAIL wide_wrap got pulses=%0d cnt=%0d exp pulses=5 cnt=1", pulses, obs_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sel = 1'b0; pl = 4; bc = 8; cnt_mod = 65536; cyc = 0;
    test_reset();
    test_single();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
